// File: rtl/seq_det_param.sv
// seq_det_param
//   Serial pattern detector for the receive path. It compares a 1-bit input
//   stream against a PAT_W-bit pattern register that can be reloaded at run
//   time. It reports each match with a one-cycle pulse, a sticky flag and a
//   saturating counter.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   in        serial data bit
//   in_valid  qualifies in on the clk edge
//   pat_load  load pat_in into the pattern register; blocks the bit that cycle
//   pat_in    new pattern, first-received bit in the MSB
//   clr       clear sat (a match on the same edge takes priority)
//   hit       registered one-cycle pulse per match
//   sat       sticky match flag
//   hit_cnt   matches since reset, saturating at all-ones
module seq_det_param #(
  parameter int               PAT_W   = 8,
  parameter logic [PAT_W-1:0] PATTERN = 8'b01111110,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clr,
  output logic             hit,
  output logic             sat,
  output logic [CNT_W-1:0] hit_cnt
);

  // The fill counter only has to reach PAT_W-1.
  localparam int             FW       = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W - 1);

  typedef enum logic {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [FW-1:0]      fill_q, fill_d;
  // Only the PAT_W-1 most recent bits are kept. The incoming bit completes
  // the comparison window.
  logic [PAT_W-2:0]   sr_q, sr_d;
  logic [PAT_W-1:0]   pat_q, pat_d;

  logic               accept;
  logic [PAT_W-1:0]   window;
  logic               match;
  logic               sat_d;
  logic [CNT_W-1:0]   cnt_d;

  // A pattern load has priority over an incoming bit, so that bit is dropped.
  assign accept = in_valid & ~pat_load;
  assign window = {sr_q, in};
  assign match  = accept && (state_q == S_ARMED) && (window == pat_q);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    sr_d    = sr_q;
    pat_d   = pat_q;

    if (pat_load) begin
      pat_d   = pat_in;
      fill_d  = '0;
      state_d = S_FILL;
    end else if (accept) begin
      sr_d = window[PAT_W-2:0];
      case (state_q)
        S_FILL: begin
          fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
          // The window becomes valid once PAT_W-1 bits are held. The next
          // accepted bit is then the first one evaluated.
          if (fill_d == FILL_MAX) state_d = S_ARMED;
        end
        S_ARMED: begin
          // In non-overlapping mode, the bits of a match cannot count toward
          // the next one.
          if (match && (OVERLAP == 0)) begin
            fill_d  = '0;
            state_d = S_FILL;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  // Output/status next values
  always_comb begin
    sat_d = sat;
    cnt_d = hit_cnt;
    if (match) begin
      sat_d = 1'b1;
      if (hit_cnt != {CNT_W{1'b1}}) cnt_d = hit_cnt + CNT_W'(1);
    end else if (clr) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      fill_q  <= '0;
      sr_q    <= '0;
      pat_q   <= PATTERN;
      hit     <= 1'b0;
      sat     <= 1'b0;
      hit_cnt <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      sr_q    <= sr_d;
      pat_q   <= pat_d;
      hit     <= match;
      sat     <= sat_d;
      hit_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param. Three configurations share one stimulus stream:
//   u0: PAT_W=8, pattern 0x7E, overlap, CNT_W=8
//   u1: PAT_W=4, pattern 1010, overlap, CNT_W=2
//   u2: PAT_W=4, pattern 1010, non-overlap, CNT_W=3
// The reference model keeps an unbounded count of accepted bits since the
// window was last restarted, along with the recent bit history as an integer.
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       in_valid = 1'b0;
  logic       pat_load = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] pat_in8 = 8'h7E;
  logic [3:0] pat_in4 = 4'hA;

  logic       hit0, sat0, hit1, sat1, hit2, sat2;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [2:0] cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_det_param #(.PAT_W(8), .PATTERN(8'b01111110), .OVERLAP(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in8), .clr(clr), .hit(hit0), .sat(sat0), .hit_cnt(cnt0));

  seq_det_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in4), .clr(clr), .hit(hit1), .sat(sat1), .hit_cnt(cnt1));

  seq_det_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(0), .CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in4), .clr(clr), .hit(hit2), .sat(sat2), .hit_cnt(cnt2));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int W  [3] = '{8, 4, 4};
  int OV [3] = '{1, 1, 0};
  int CM [3] = '{255, 3, 7};
  int mpat[3], hv[3], hn[3], ehit[3], esat[3], ecnt[3];

  task automatic model_reset();
    mpat = '{126, 10, 10};
    for (int k = 0; k < 3; k++) begin
      hv[k] = 0; hn[k] = 0; ehit[k] = 0; esat[k] = 0; ecnt[k] = 0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      bit m;
      m = 0;
      ehit[k] = 0;
      if (pat_load) begin
        mpat[k] = (k == 0) ? int'(pat_in8) : int'(pat_in4);
        hn[k] = 0;
      end else if (in_valid) begin
        hv[k] = ((hv[k] * 2) + int'(din)) % 256;
        hn[k]++;
        if (hn[k] >= W[k] && (hv[k] % (1 << W[k])) == mpat[k]) m = 1;
      end
      if (m) begin
        ehit[k] = 1;
        esat[k] = 1;
        if (ecnt[k] < CM[k]) ecnt[k]++;
        if (OV[k] == 0) hn[k] = 0;
      end else if (clr) begin
        esat[k] = 0;
      end
    end
  endtask

  // Advance the model on each rising edge and compare on the following
  // falling edge. An asynchronous reset seen at compare time resets the
  // model too.
  initial begin
    int ah[3], as[3], ac[3];
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (rst) model_reset();
      ah = '{int'(hit0), int'(hit1), int'(hit2)};
      as = '{int'(sat0), int'(sat1), int'(sat2)};
      ac = '{int'(cnt0), int'(cnt1), int'(cnt2)};
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d.hit", k), ah[k], ehit[k]);
        chk($sformatf("u%0d.sat", k), as[k], esat[k]);
        chk($sformatf("u%0d.hit_cnt", k), ac[k], ecnt[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic iv, input logic b, input logic ld, input logic c);
    in_valid = iv; din = b; pat_load = ld; clr = c;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendv(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drv(1'b1, v[i], 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 0; pat_load = 0; clr = 0; rst = 1;
    @(posedge clk); #2;
    rst = 0;
  endtask

  initial begin
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 0;
    chk("reset_hit", int'(hit0), 0);
    chk("reset_sat", int'(sat0), 0);
    chk("reset_cnt", int'(cnt0), 0);

    // T1: the flag 01111110 with the default pattern
    sendv(16'h007E, 8);
    chk("t1_hit", int'(hit0), 1);
    idle(1);
    chk("t1_hit_drop", int'(hit0), 0);
    chk("t1_cnt", int'(cnt0), 1);
    chk("t1_sat", int'(sat0), 1);

    // T2: 101010 against pattern 1010, overlapping and non-overlapping
    do_reset();
    sendv(16'b101010, 6);
    chk("t2_cnt_ovl", int'(cnt1), 2);
    chk("t2_cnt_novl", int'(cnt2), 1);

    // T3: a reset in the middle of the pattern drops the partial history
    do_reset();
    sendv(16'b0111111, 7);
    do_reset();
    drv(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("t3_cnt", int'(cnt0), 0);
    chk("t3_sat", int'(sat0), 0);

    // T4: idle gaps of 3 cycles between the bits of 0x7E
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      drv(1'b1, 1'(8'h7E >> i), 1'b0, 1'b0);
      idle(3);
    end
    chk("t4_cnt", int'(cnt0), 1);

    // T5: reload the pattern with 0xA5; the old flag no longer matches
    do_reset();
    pat_in8 = 8'hA5;
    drv(1'b1, 1'b1, 1'b1, 1'b0);
    sendv(16'h00A5, 8);
    chk("t5_hit", int'(hit0), 1);
    sendv(16'h007E, 8);
    idle(1);
    chk("t5_cnt", int'(cnt0), 1);

    // T6: counter saturation at CNT_W=2; clr on a matching edge loses to set
    do_reset();
    sendv(16'b10101010101, 11);
    drv(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t6_sat_kept", int'(sat1), 1);
    chk("t6_cnt_sat", int'(cnt1), 3);
    chk("t6_cnt_novl", int'(cnt2), 3);
    drv(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_sat_clr", int'(sat1), 0);
    chk("t6_cnt_hold", int'(cnt1), 3);

    // Random traffic: occasional loads, clears and resets
    for (int i = 0; i < 3000; i++) begin
      logic ld;
      ld = ($urandom_range(0, 99) == 0);
      if (ld) begin
        pat_in8 = 8'($urandom);
        pat_in4 = 4'($urandom);
      end
      rst = ($urandom_range(0, 499) == 0);
      drv(($urandom_range(0, 3) != 0), 1'($urandom), ld,
          ($urandom_range(0, 19) == 0));
    end
    rst = 0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
